elastic_ra_fifo: RTL and testbench

//  Parametrised synchronous FIFO with a second, random-access read port that peeks any

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ram_1w2r.sv | 46 ++++
 rtl/elastic_ra_fifo.sv | 136 +++++++++++++
 tb/tb_elastic_ra_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the elastic random-access FIFO: address-width math and
// elaboration-time parameter sanity checks.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2_min4(input int unsigned n);
    return (n >= 4) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit levels_ok(input int unsigned depth, input int unsigned af_level,
                                   input int unsigned ae_level);
    return (af_level <= depth) && (ae_level < depth);
  endfunction

endpackage

// File: rtl/fifo_ram_1w2r.sv
// DEPTH x DATA_W storage with one synchronous write port and two independent
// synchronous read ports; read registers hold when their enable is low.
module fifo_ram_1w2r #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_a_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic              re_b_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  // Storage is never cleared; only the read registers see reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Reads return pre-edge contents, so a same-slot write is not visible yet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (re_a_i) rdata_a_q <= mem[raddr_a_i];
      if (re_b_i) rdata_b_q <= mem[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/elastic_ra_fifo.sv
// Synchronous FIFO with a second read port that peeks any occupied entry relative
// to the head without popping it; flush, thresholds and error pulses included.
module elastic_ra_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AF_LEVEL = 28,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  input  logic                     peek_en,
  input  logic [clog2(DEPTH)-1:0]  peek_idx,
  output logic [DATA_W-1:0]        peek_data,
  output logic                     peek_valid,
  output logic                     buf_empty,
  output logic                     buf_full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [clog2(DEPTH):0]    counter,
  output logic                     wr_err,
  output logic                     rd_err
);

  localparam int unsigned AW   = clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;

  localparam logic [AW-1:0]   PtrOne   = AW'(1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAf    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] CntAe    = CntW'(AE_LEVEL);

  if (!is_pow2_min4(DEPTH)) begin : g_bad_depth
    $error("elastic_ra_fifo: DEPTH must be a power of two and at least 4");
  end
  if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("elastic_ra_fifo: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
  end

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_err_q, wr_err_d;
  logic            rd_err_q, rd_err_d;
  logic            peek_valid_q, peek_valid_d;

  logic            pop_ok;
  logic            push_ok;
  logic            peek_ok;
  logic [AW-1:0]   peek_addr;

  // A pop frees a slot in the same edge, so a full FIFO still takes a paired push.
  assign pop_ok    = rd_en & (cnt_q != '0);
  assign push_ok   = wr_en & ((cnt_q != CntFull) | pop_ok);
  assign peek_ok   = peek_en & ({1'b0, peek_idx} < cnt_q);
  assign peek_addr = rd_ptr_q + peek_idx;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    wr_err_d     = 1'b0;
    rd_err_d     = 1'b0;
    peek_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CntOne;
        2'b01:   cnt_d = cnt_q - CntOne;
        default: cnt_d = cnt_q;
      endcase
      wr_err_d     = wr_en & ~push_ok;
      rd_err_d     = rd_en & ~pop_ok;
      peek_valid_d = peek_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      peek_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      wr_err_q     <= wr_err_d;
      rd_err_q     <= rd_err_d;
      peek_valid_q <= peek_valid_d;
    end
  end

  // Flush blocks every RAM access so data_out and peek_data hold across it.
  fifo_ram_1w2r #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (push_ok & ~flush & ~rst),
    .waddr_i   (wr_ptr_q),
    .wdata_i   (data_in),
    .re_a_i    (pop_ok & ~flush),
    .raddr_a_i (rd_ptr_q),
    .rdata_a_o (data_out),
    .re_b_i    (peek_ok & ~flush),
    .raddr_b_i (peek_addr),
    .rdata_b_o (peek_data)
  );

  assign counter      = cnt_q;
  assign buf_empty    = (cnt_q == '0);
  assign buf_full     = (cnt_q == CntFull);
  assign almost_full  = (cnt_q >= CntAf);
  assign almost_empty = (cnt_q <= CntAe);
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;
  assign peek_valid   = peek_valid_q;

endmodule

// File: tb/tb_elastic_ra_fifo.sv
// Self-checking bench for elastic_ra_fifo: queue-based reference model, a vector
// table, directed corner sequences and a randomized soak.
module tb_elastic_ra_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int AF    = 28;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, rd_en, peek_en;
  logic [DW-1:0] data_in;
  logic [AW-1:0] peek_idx;
  logic [DW-1:0] data_out, peek_data;
  logic          peek_valid, buf_empty, buf_full, almost_full, almost_empty;
  logic [AW:0]   counter;
  logic          wr_err, rd_err;

  elastic_ra_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .peek_en      (peek_en),
    .peek_idx     (peek_idx),
    .peek_data    (peek_data),
    .peek_valid   (peek_valid),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .counter      (counter),
    .wr_err       (wr_err),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, head at index 0.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic [DW-1:0] m_pk   = '0;
  bit            m_pv   = 1'b0;
  bit            m_werr = 1'b0;
  bit            m_rerr = 1'b0;

  typedef struct {
    bit            rs, fl, wr;
    logic [DW-1:0] din;
    bit            rd, pk;
    logic [AW-1:0] idx;
    int            e_cnt;
    logic [DW-1:0] e_dout;
    bit            e_pv;
    logic [DW-1:0] e_pk;
    bit            e_werr, e_rerr;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit fl, input bit wr, input logic [DW-1:0] din,
                              input bit rd, input bit pk, input logic [AW-1:0] idx);
    int  n;
    bit  pop, push;
    if (r) begin
      q.delete();
      m_dout = '0; m_pk = '0; m_pv = 0; m_werr = 0; m_rerr = 0;
    end else if (fl) begin
      q.delete();
      m_pv = 0; m_werr = 0; m_rerr = 0;
    end else begin
      n    = q.size();
      pop  = rd && (n > 0);
      push = wr && ((n < DEPTH) || pop);
      if (pk && (int'(idx) < n)) begin
        m_pk = q[idx];
        m_pv = 1;
      end else begin
        m_pv = 0;
      end
      if (pop)  m_dout = q.pop_front();
      if (push) q.push_back(din);
      m_werr = wr && !push;
      m_rerr = rd && !pop;
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("counter",      32'(counter),      32'(n));
    chk("buf_empty",    32'(buf_empty),    32'(n == 0));
    chk("buf_full",     32'(buf_full),     32'(n == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("data_out",     32'(data_out),     32'(m_dout));
    chk("peek_valid",   32'(peek_valid),   32'(m_pv));
    chk("peek_data",    32'(peek_data),    32'(m_pk));
    chk("wr_err",       32'(wr_err),       32'(m_werr));
    chk("rd_err",       32'(rd_err),       32'(m_rerr));
  endtask

  // One clock: drive, clock, sample #1 after the edge, compare against the model.
  task automatic step(input bit r, input bit fl, input bit wr, input logic [DW-1:0] din,
                      input bit rd, input bit pk, input logic [AW-1:0] idx);
    rst = r; flush = fl; wr_en = wr; data_in = din; rd_en = rd; peek_en = pk; peek_idx = idx;
    @(posedge clk);
    #1;
    model_update(r, fl, wr, din, rd, pk, idx);
    check_all();
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(0, 0, 1, d, 0, 0, '0);
  endtask

  task automatic pop();
    step(0, 0, 0, '0, 1, 0, '0);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    rst = 1; flush = 0; wr_en = 0; rd_en = 0; peek_en = 0; data_in = '0; peek_idx = '0;

    // Fill from reset; almost_full rises on the 28th write.
    step(1, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i));
      chk("af_at_write", 32'(almost_full), 32'(i + 1 >= AF));
    end
    chk("fill_full", 32'(buf_full), 32'd1);
    chk("fill_count", 32'(counter), 32'd32);

    // Push into full: one-cycle wr_err, then drain in order.
    push(8'hAA);
    chk("full_wr_err", 32'(wr_err), 32'd1);
    chk("full_count", 32'(counter), 32'd32);
    idle();
    chk("wr_err_pulse", 32'(wr_err), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      chk("drain_order", 32'(data_out), 32'(i));
    end

    // Pop from empty.
    pop();
    chk("empty_rd_err", 32'(rd_err), 32'd1);
    chk("empty_hold", 32'(data_out), 32'h1F);
    chk("empty_flag", 32'(buf_empty), 32'd1);

    // Vector table: rs fl wr din rd pk idx | cnt dout pv pk werr rerr
    vt[0]  = '{1, 0, 0, 8'h00, 0, 0, 5'd0, 0, 8'h00, 0, 8'h00, 0, 0};
    vt[1]  = '{0, 0, 0, 8'h00, 1, 0, 5'd0, 0, 8'h00, 0, 8'h00, 0, 1};
    vt[2]  = '{0, 0, 1, 8'h10, 0, 0, 5'd0, 1, 8'h00, 0, 8'h00, 0, 0};
    vt[3]  = '{0, 0, 1, 8'h11, 0, 0, 5'd0, 2, 8'h00, 0, 8'h00, 0, 0};
    vt[4]  = '{0, 0, 1, 8'h12, 0, 0, 5'd0, 3, 8'h00, 0, 8'h00, 0, 0};
    vt[5]  = '{0, 0, 1, 8'h13, 0, 0, 5'd0, 4, 8'h00, 0, 8'h00, 0, 0};
    vt[6]  = '{0, 0, 1, 8'h14, 0, 0, 5'd0, 5, 8'h00, 0, 8'h00, 0, 0};
    vt[7]  = '{0, 0, 0, 8'h00, 0, 1, 5'd3, 5, 8'h00, 1, 8'h13, 0, 0};
    vt[8]  = '{0, 0, 0, 8'h00, 0, 1, 5'd5, 5, 8'h00, 0, 8'h13, 0, 0};
    vt[9]  = '{0, 0, 0, 8'h00, 1, 1, 5'd0, 4, 8'h10, 1, 8'h10, 0, 0};
    vt[10] = '{0, 0, 1, 8'h20, 1, 1, 5'd4, 4, 8'h11, 0, 8'h10, 0, 0};
    vt[11] = '{0, 1, 1, 8'h55, 1, 1, 5'd0, 0, 8'h11, 0, 8'h10, 0, 0};
    vt[12] = '{0, 0, 0, 8'h00, 1, 0, 5'd0, 0, 8'h11, 0, 8'h10, 0, 1};
    vt[13] = '{0, 0, 1, 8'h77, 1, 0, 5'd0, 1, 8'h11, 0, 8'h10, 0, 1};
    vt[14] = '{0, 0, 0, 8'h00, 1, 0, 5'd0, 0, 8'h77, 0, 8'h10, 0, 0};
    for (int i = 0; i < 15; i++) begin
      step(vt[i].rs, vt[i].fl, vt[i].wr, vt[i].din, vt[i].rd, vt[i].pk, vt[i].idx);
      chk("vec_cnt",  32'(counter),    32'(vt[i].e_cnt));
      chk("vec_dout", 32'(data_out),   32'(vt[i].e_dout));
      chk("vec_pv",   32'(peek_valid), 32'(vt[i].e_pv));
      chk("vec_pk",   32'(peek_data),  32'(vt[i].e_pk));
      chk("vec_werr", 32'(wr_err),     32'(vt[i].e_werr));
      chk("vec_rerr", 32'(rd_err),     32'(vt[i].e_rerr));
    end

    // Full with paired push+pop: both accepted, 0x55 lands at the tail.
    step(1, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i));
    step(0, 0, 1, 8'h55, 1, 0, '0);
    chk("pair_cnt",  32'(counter),  32'd32);
    chk("pair_dout", 32'(data_out), 32'h40);
    chk("pair_werr", 32'(wr_err),   32'd0);
    for (int i = 0; i < DEPTH; i++) pop();
    chk("pair_tail", 32'(data_out), 32'h55);

    // Wrapped pointers at counter 7, flush with a concurrent push.
    step(1, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 30; i++) begin
      push(8'(i));
      pop();
    end
    for (int i = 0; i < 7; i++) push(8'(8'hC0 + i));
    chk("wrap_cnt", 32'(counter), 32'd7);
    step(0, 1, 1, 8'h99, 0, 0, '0);
    chk("flush_cnt",   32'(counter),   32'd0);
    chk("flush_empty", 32'(buf_empty), 32'd1);
    push(8'h3C);
    pop();
    chk("post_flush", 32'(data_out), 32'h3C);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++) push(8'(8'hE0 + i));
    step(0, 0, 1, 8'hE5, 1, 1, 5'd1);
    step(1, 0, 1, 8'hE6, 1, 1, 5'd0);
    chk("rst_dout", 32'(data_out),   32'd0);
    chk("rst_pk",   32'(peek_data),  32'd0);
    chk("rst_pv",   32'(peek_valid), 32'd0);
    chk("rst_cnt",  32'(counter),    32'd0);
    chk("rst_ae",   32'(almost_empty), 32'd1);

    // Randomized soak with phases biased towards filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int  wp;
      bit  r, fl, wr, rd, pk;
      wp = ((i / 200) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(0, 999) < 3);
      fl = ($urandom_range(0, 99) < 1);
      wr = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      pk = ($urandom_range(0, 1) == 1);
      step(r, fl, wr, 8'($urandom), rd, pk, 5'($urandom_range(0, DEPTH - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
